// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: state encodings,
// counter width and the load-use compare.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd3
    } state_e;

    localparam int unsigned REG_W = 3;
    localparam int unsigned CNT_W = 2;

    // True when the instruction in decode reads a register that the load
    // sitting at the decode/ALU buffer output has not yet produced.
    function automatic logic load_use_hazard(
        input logic             ex_mem_read,
        input logic [REG_W-1:0] rdst,
        input logic [REG_W-1:0] rsrc1,
        input logic [REG_W-1:0] rsrc2,
        input logic             use1,
        input logic             use2
    );
        return ex_mem_read && ((use1 && (rsrc1 == rdst)) || (use2 && (rsrc2 == rdst)));
    endfunction

endpackage

// File: rtl/stall_counter.sv
// 2-bit down-counter shared by the load-use stall and memory freeze waits.
// Load wins over decrement; decrement saturates at zero.
module stall_counter
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last,
    output logic             o_zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);
    assign o_last = (count_q == CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// multi-word memory freezes, all decided combinationally in the same cycle.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LU_STALL  = 1,
    parameter int unsigned MEM_EXTRA = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] i_dec_rsrc1,
    input  logic [REG_W-1:0] i_dec_rsrc2,
    input  logic             i_dec_use1,
    input  logic             i_dec_use2,
    input  logic [REG_W-1:0] i_ex_rdst,
    input  logic             i_ex_mem_read,
    input  logic             i_br_taken,
    input  logic             i_mem_multi,
    output logic             o_pc_hold,
    output logic             o_fd_en,
    output logic             o_da_en,
    output logic             o_am_en,
    output logic             o_fd_flush,
    output logic             o_da_flush,
    output logic [1:0]       o_state
);

    state_e           state_q;
    state_e           state_d;
    logic             hazard;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_last;
    logic             cnt_zero;

    assign hazard = load_use_hazard(i_ex_mem_read, i_ex_rdst, i_dec_rsrc1,
                                    i_dec_rsrc2, i_dec_use1, i_dec_use2);

    stall_counter u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (cnt_load),
        .i_load_val (cnt_load_val),
        .i_dec      (cnt_dec),
        .o_last     (cnt_last),
        .o_zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        o_pc_hold    = 1'b0;
        o_fd_en      = 1'b1;
        o_da_en      = 1'b1;
        o_am_en      = 1'b1;
        o_fd_flush   = 1'b0;
        o_da_flush   = 1'b0;

        case (state_q)
            ST_RUN, ST_LDSTALL: begin
                if (i_mem_multi) begin
                    o_pc_hold    = 1'b1;
                    o_fd_en      = 1'b0;
                    o_da_en      = 1'b0;
                    o_am_en      = 1'b0;
                    state_d      = ST_MEMWAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(MEM_EXTRA);
                end else if (i_br_taken) begin
                    o_fd_flush = 1'b1;
                    o_da_flush = 1'b1;
                    state_d    = ST_RUN;
                end else if ((state_q == ST_LDSTALL) || hazard) begin
                    o_pc_hold  = 1'b1;
                    o_fd_en    = 1'b0;
                    o_da_flush = 1'b1;
                    if (state_q == ST_RUN) begin
                        // The detecting cycle is itself the first bubble.
                        if (LU_STALL > 1) begin
                            state_d      = ST_LDSTALL;
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(LU_STALL - 1);
                        end
                    end else begin
                        cnt_dec = 1'b1;
                        if (cnt_last || cnt_zero) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            ST_MEMWAIT: begin
                o_pc_hold = 1'b1;
                o_fd_en   = 1'b0;
                o_da_en   = 1'b0;
                o_am_en   = 1'b0;
                cnt_dec   = 1'b1;
                if (cnt_last || cnt_zero) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Reset flushes the resetless pipeline buffers.
        if (rst) begin
            state_d    = ST_RUN;
            cnt_load   = 1'b0;
            cnt_dec    = 1'b0;
            o_pc_hold  = 1'b0;
            o_fd_en    = 1'b1;
            o_da_en    = 1'b1;
            o_am_en    = 1'b1;
            o_fd_flush = 1'b1;
            o_da_flush = 1'b1;
        end
    end

    assign o_state = rst ? 2'(ST_RUN) : state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Drives two controllers (LU_STALL=1/MEM_EXTRA=1 and LU_STALL=3/MEM_EXTRA=2)
// with shared directed vectors and checks both against a counting model.
module tb_hazard_ctrl;

    localparam int LU_A = 1;
    localparam int ME_A = 1;
    localparam int LU_B = 3;
    localparam int ME_B = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, mm;

    logic       a_pc_hold, a_fd_en, a_da_en, a_am_en, a_fd_flush, a_da_flush;
    logic [1:0] a_state;
    logic       b_pc_hold, b_fd_en, b_da_en, b_am_en, b_fd_flush, b_da_flush;
    logic [1:0] b_state;

    logic [7:0] out_a, out_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stall_left[2];
    int freeze_left[2];

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL(LU_A), .MEM_EXTRA(ME_A)) dut_a (
        .clk(clk), .rst(rst),
        .i_dec_rsrc1(rs1), .i_dec_rsrc2(rs2), .i_dec_use1(u1), .i_dec_use2(u2),
        .i_ex_rdst(rd), .i_ex_mem_read(mr), .i_br_taken(br), .i_mem_multi(mm),
        .o_pc_hold(a_pc_hold), .o_fd_en(a_fd_en), .o_da_en(a_da_en), .o_am_en(a_am_en),
        .o_fd_flush(a_fd_flush), .o_da_flush(a_da_flush), .o_state(a_state)
    );

    hazard_ctrl #(.LU_STALL(LU_B), .MEM_EXTRA(ME_B)) dut_b (
        .clk(clk), .rst(rst),
        .i_dec_rsrc1(rs1), .i_dec_rsrc2(rs2), .i_dec_use1(u1), .i_dec_use2(u2),
        .i_ex_rdst(rd), .i_ex_mem_read(mr), .i_br_taken(br), .i_mem_multi(mm),
        .o_pc_hold(b_pc_hold), .o_fd_en(b_fd_en), .o_da_en(b_da_en), .o_am_en(b_am_en),
        .o_fd_flush(b_fd_flush), .o_da_flush(b_da_flush), .o_state(b_state)
    );

    // Layout: [7:6] state, pc_hold, fd_en, da_en, am_en, fd_flush, da_flush
    assign out_a = {a_state, a_pc_hold, a_fd_en, a_da_en, a_am_en, a_fd_flush, a_da_flush};
    assign out_b = {b_state, b_pc_hold, b_fd_en, b_da_en, b_am_en, b_fd_flush, b_da_flush};

    function automatic logic [7:0] pack(input int st, input bit pc, input bit fe,
                                        input bit de, input bit ae, input bit ff,
                                        input bit df);
        logic [1:0] s;
        s = st[1:0];
        return {s, pc, fe, de, ae, ff, df};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    // Model: bubbles still owed and freeze cycles still owed per instance.
    always @(negedge clk) begin
        bit         hz;
        int         lu, me, st;
        logic [7:0] exp;
        hz = mr && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        for (int i = 0; i < 2; i++) begin
            lu = (i == 0) ? LU_A : LU_B;
            me = (i == 0) ? ME_A : ME_B;
            st = (freeze_left[i] > 0) ? 3 : ((stall_left[i] > 0) ? 1 : 0);
            if (rst) begin
                exp = pack(0, 0, 1, 1, 1, 1, 1);
                stall_left[i]  = 0;
                freeze_left[i] = 0;
            end else if (freeze_left[i] > 0) begin
                exp = pack(3, 1, 0, 0, 0, 0, 0);
                freeze_left[i] = freeze_left[i] - 1;
            end else if (mm) begin
                exp = pack(st, 1, 0, 0, 0, 0, 0);
                freeze_left[i] = me;
                stall_left[i]  = 0;
            end else if (br) begin
                exp = pack(st, 0, 1, 1, 1, 1, 1);
                stall_left[i] = 0;
            end else if (stall_left[i] > 0 || hz) begin
                exp = pack(st, 1, 0, 1, 1, 0, 1);
                stall_left[i] = (stall_left[i] > 0) ? stall_left[i] - 1 : lu - 1;
            end else begin
                exp = pack(0, 0, 1, 1, 1, 0, 0);
            end
            chk((i == 0) ? "model_A" : "model_B", (i == 0) ? out_a : out_b, exp);
        end
        $display("cyc=%0d rst=%b mr=%b br=%b mm=%b A=%b B=%b", cyc, rst, mr, br, mm, out_a, out_b);
        cyc++;
    end

    task automatic apply(input logic r, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [2:0] d, input logic e1, input logic e2,
                         input logic m, input logic b, input logic x);
        @(posedge clk);
        #1;
        rst = r; rs1 = s1; rs2 = s2; rd = d;
        u1 = e1; u2 = e2; mr = m; br = b; mm = x;
        #2;
    endtask

    task automatic idle();
        apply(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0;
        u1 = 0; u2 = 0; mr = 0; br = 0; mm = 0;
        stall_left  = '{0, 0};
        freeze_left = '{0, 0};

        apply(1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0);
        apply(1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0);
        chk("reset_A", out_a, 8'b00011111);
        chk("reset_B", out_b, 8'b00011111);
        idle();
        chk("idle_A", out_a, 8'b00011100);

        // Load-use on rsrc1
        apply(0, 3'd3, 3'd0, 3'd3, 1, 0, 1, 0, 0);
        chk("req032_stall_A", out_a, 8'b00101101);
        chk("req032_stall_B", out_b, 8'b00101101);
        idle();
        chk("req032_release_A", out_a, 8'b00011100);
        chk("lu3_bubble2_B", out_b, 8'b01101101);
        idle();
        chk("lu3_bubble3_B", out_b, 8'b01101101);
        idle();
        chk("lu3_done_B", out_b, 8'b00011100);

        // Matching register but not read
        apply(0, 3'd3, 3'd5, 3'd3, 0, 1, 1, 0, 0);
        chk("req033_nostall_A", out_a, 8'b00011100);

        // Load-use on rsrc2
        apply(0, 3'd0, 3'd4, 3'd4, 0, 1, 1, 0, 0);
        chk("rsrc2_stall_A", out_a, 8'b00101101);
        idle(); idle(); idle();

        // Branch cancels pending stall
        apply(0, 3'd3, 3'd0, 3'd3, 1, 0, 1, 0, 0);
        apply(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0);
        chk("req034_flush_B", out_b, 8'b01011111);
        chk("br_flush_A", out_a, 8'b00011111);
        idle();
        chk("req034_run_B", out_b, 8'b00011100);

        // mem_multi beats br_taken; br re-presented until accepted
        apply(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 1);
        chk("req035_freeze_A", out_a, 8'b00100000);
        apply(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0);
        chk("req035_hold_A", out_a, 8'b11100000);
        apply(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0);
        chk("req035_flush_A", out_a, 8'b00011111);
        chk("me2_hold_B", out_b, 8'b11100000);
        apply(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0);
        chk("me2_flush_B", out_b, 8'b00011111);
        idle();

        // Priority: branch over load-use
        apply(0, 3'd3, 3'd0, 3'd3, 1, 0, 1, 1, 0);
        chk("prio_br_A", out_a, 8'b00011111);
        idle();

        // Priority: mem over load-use; hazard ignored in MEMWAIT then re-evaluated
        apply(0, 3'd3, 3'd0, 3'd3, 1, 0, 1, 0, 1);
        chk("prio_mem_A", out_a, 8'b00100000);
        apply(0, 3'd3, 3'd0, 3'd3, 1, 0, 1, 0, 0);
        chk("memwait_ignore_A", out_a, 8'b11100000);
        apply(0, 3'd3, 3'd0, 3'd3, 1, 0, 1, 0, 0);
        chk("reeval_A", out_a, 8'b00101101);
        idle(); idle(); idle(); idle();

        // Stall interrupted by memory freeze does not resume
        apply(0, 3'd3, 3'd0, 3'd3, 1, 0, 1, 0, 0);
        apply(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 1);
        chk("stall_into_mem_B", out_b, 8'b01100000);
        idle(); idle(); idle();
        chk("no_resume_B", out_b, 8'b00011100);

        // Reset aborts MEMWAIT
        apply(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 1);
        apply(1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0);
        chk("req036_rst_A", out_a, 8'b00011111);
        chk("req036_rst_B", out_b, 8'b00011111);
        apply(1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0);
        chk("req036_held_B", out_b, 8'b00011111);
        idle();
        chk("post_rst_A", out_a, 8'b00011100);
        chk("post_rst_B", out_b, 8'b00011100);
        idle();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LU_STALL, default 1: bubble cycles inserted per load-use hazard (range 1..3).
REQ-002 Parameter MEM_EXTRA, default 1: extra freeze cycles per two-word memory access (range 1..3).
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_dec_rsrc1, i_dec_rsrc2  in  3 each  source registers of the instruction in decode.
REQ-006 i_dec_use1, i_dec_use2  in  1 each  decode instruction actually reads rsrc1 / rsrc2.
REQ-007 i_ex_rdst  in  3  destination register at the decode/ALU buffer output.
REQ-008 i_ex_mem_read  in  1  instruction at the decode/ALU buffer output is a memory read.
REQ-009 i_br_taken  in  1  ALU stage resolved a taken branch or jump this cycle.
REQ-010 i_mem_multi  in  1  memory stage starts a two-word (32-bit PC) access this cycle.
REQ-011 o_pc_hold  out  1  PC register keeps its value.
REQ-012 o_fd_en, o_da_en, o_am_en  out  1 each  enables of the fetch/decode, decode/ALU and ALU/memory buffers.
REQ-013 o_fd_flush, o_da_flush  out  1 each  buffer loads all-zero (bubble) instead of its inputs.
REQ-014 o_state  out  2  current state encoding: RUN=0, LDSTALL=1, MEMWAIT=3.

Function
REQ-015 Idle (RUN, no event) SHALL drive all enables 1, all flushes 0, o_pc_hold 0.
REQ-016 Load-use hazard: i_ex_mem_read and ((i_dec_use1 and rsrc1==rdst) or (i_dec_use2 and rsrc2==rdst)).
REQ-017 Hazard in RUN, same cycle: o_pc_hold=1, o_fd_en=0, o_da_flush=1; if LU_STALL>1, next state LDSTALL with counter=LU_STALL-1.
REQ-018 LDSTALL SHALL hold the REQ-017 outputs, decrement the counter each cycle and return to RUN after the cycle in which the counter reaches 1.
REQ-019 Total bubble count per hazard SHALL equal LU_STALL exactly; the hazard is re-evaluated in RUN afterwards.
REQ-020 i_br_taken in RUN or LDSTALL SHALL, same cycle, force o_fd_flush=1, o_da_flush=1, o_pc_hold=0, o_fd_en=1; it cancels a pending stall and the next state is RUN.
REQ-021 i_mem_multi in RUN or LDSTALL, same cycle: o_pc_hold=1, o_fd_en=0, o_da_en=0, o_am_en=0, no flushes; next state MEMWAIT with counter=MEM_EXTRA.
REQ-022 MEMWAIT SHALL hold the REQ-021 outputs for MEM_EXTRA cycles, then return to RUN.
REQ-023 In MEMWAIT, i_br_taken, i_mem_multi and hazards SHALL be ignored (the upstream stages are frozen and re-present them).
REQ-024 Simultaneous-event priority: i_mem_multi over i_br_taken over load-use.
REQ-025 A stall interrupted by MEMWAIT SHALL not resume; the hazard is re-evaluated on return to RUN.
REQ-026 All outputs are combinational from state, counter and inputs; there is no added latency.

Reset
REQ-027 While rst=1, outputs SHALL be: o_fd_flush=1, o_da_flush=1, all enables 1, o_pc_hold=0, o_state=0. This clears the resetless pipeline buffers.
REQ-028 On the first posedge with rst=1: state RUN, counter 0.
REQ-029 rst SHALL override every event and abort LDSTALL or MEMWAIT mid-count.

Structure
REQ-030 State encodings and the hazard-compare function SHALL live in shared package pipe_pkg.
REQ-031 Both wait counts SHALL share one 2-bit down-counter in the sole sub-module stall_counter (load, decrement, zero flag).

Verification
REQ-032 LU_STALL=1: ex_mem_read=1, rdst=3, dec_use1=1, rsrc1=3 -> one cycle of pc_hold=1, fd_en=0, da_flush=1; next cycle idle outputs.
REQ-033 Same as REQ-032 with rsrc1=3 but dec_use1=0 -> no stall.
REQ-034 LU_STALL=3, hazard, then i_br_taken=1 in the 2nd stall cycle -> that cycle fd_flush=1, da_flush=1, pc_hold=0; following cycle state RUN.
REQ-035 MEM_EXTRA=1: mem_multi with br_taken=1 in the same cycle -> 2 cycles of all enables 0, no flush; br_taken re-presented afterwards flushes.
REQ-036 rst=1 mid-MEMWAIT -> next cycle o_state=0 and flushes=1 while rst is held.
